// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcodes, ROB entry types,
// default sizes and the reorder-buffer entry record.
package tomasulo_pkg;

    localparam int DEPTH_D  = 8;
    localparam int TAG_W_D  = 3;
    localparam int DATA_W_D = 16;
    localparam int ADDR_W   = 8;
    localparam int RD_W     = 4;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_LD   = 4'b0100;
    localparam logic [3:0] OP_ST   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_BNEQ = 4'b0111;

    typedef enum logic [1:0] {
        T_ALU    = 2'd0,
        T_LOAD   = 2'd1,
        T_STORE  = 2'd2,
        T_BRANCH = 2'd3
    } rob_type_t;

    typedef struct packed {
        logic                valid;
        logic                ready;
        rob_type_t           typ;
        logic [RD_W-1:0]     rd;
        logic [DATA_W_D-1:0] value;
        logic [ADDR_W-1:0]   addr;
        logic                mispredict;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order retirement: allocates at the tail,
// completes from the CDB and retires one head entry per cycle.
module rob_commit_unit
    import tomasulo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_D,
    parameter int TAG_W  = TAG_W_D,
    parameter int DATA_W = DATA_W_D
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [1:0]        issue_type,
    input  logic [3:0]        issue_rd,
    output logic              issue_ready,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic [7:0]        cdb_addr,
    input  logic              cdb_mispredict,
    output logic              commit_valid,
    output logic [3:0]        commit_rd,
    output logic [DATA_W-1:0] commit_value,
    output logic [TAG_W-1:0]  commit_tag,
    output logic              mem_we,
    output logic [7:0]        mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              flush,
    output logic              rob_empty
);

    localparam logic [TAG_W:0]   FULL    = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE = 1;
    localparam logic [TAG_W-1:0] PTR_ONE = 1;

    rob_entry_t       ent [DEPTH];
    rob_entry_t       hd;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;

    logic retire;
    logic retire_flush;
    logic do_issue;
    logic do_wb;

    // Head retire decision and handshake qualifiers from registered state
    always_comb begin
        hd           = ent[head];
        retire       = hd.valid && hd.ready;
        retire_flush = retire && (hd.typ == T_BRANCH) && hd.mispredict;
        issue_ready  = (count != FULL) && !retire_flush;
        do_issue     = issue_valid && issue_ready;
        do_wb        = cdb_valid && ent[cdb_tag].valid && !retire_flush;
        issue_tag    = tail;
        rob_empty    = (count == '0);
    end

    // Entry storage: allocate, complete, retire; a flush drops everything
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (retire_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
                ent[i].ready <= 1'b0;
            end
        end else begin
            if (do_issue) begin
                ent[tail].valid      <= 1'b1;
                ent[tail].ready      <= 1'b0;
                ent[tail].typ        <= rob_type_t'(issue_type);
                ent[tail].rd         <= issue_rd;
                ent[tail].mispredict <= 1'b0;
            end
            if (do_wb) begin
                ent[cdb_tag].ready      <= 1'b1;
                ent[cdb_tag].value      <= cdb_value;
                ent[cdb_tag].addr       <= cdb_addr;
                ent[cdb_tag].mispredict <= cdb_mispredict;
            end
            if (retire) begin
                ent[head].valid <= 1'b0;
            end
        end
    end

    // Head/tail pointers and occupancy count
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (retire_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (retire) begin
                head <= head + PTR_ONE;
            end
            if (do_issue) begin
                tail <= tail + PTR_ONE;
            end
            unique case ({do_issue, retire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Registered retire outputs: pulses for one cycle, data held
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_value <= '0;
            commit_tag   <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            flush        <= 1'b0;
        end else begin
            commit_valid <= retire;
            mem_we       <= retire && (hd.typ == T_STORE);
            flush        <= retire_flush;
            if (retire) begin
                commit_tag <= head;
                unique case (hd.typ)
                    T_ALU, T_LOAD: begin
                        commit_rd    <= hd.rd;
                        commit_value <= hd.value;
                    end
                    T_STORE: begin
                        commit_rd <= '0;
                        mem_addr  <= hd.addr;
                        mem_wdata <= hd.value;
                    end
                    T_BRANCH: begin
                        commit_rd <= '0;
                    end
                    default: begin
                        commit_rd <= '0;
                    end
                endcase
            end
        end
    end

endmodule
